mux_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one 32:1 word multiplexer (5-bit select) among up to 32 requesters.
- Drives the mux select with a registered value and a one-hot grant.
- Holds each grant until the owner signals done, or until a hold timeout expires.
- Sits between the requesting units (register read clients, peripheral data sources) and the select input of the shared datapath mux.

---
 rtl/mux_rr_arbiter_if.sv | 24 ++
 rtl/mux_rr_arbiter.sv | 153 +++++++++++++++
 tb/tb_mux_rr_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle between requesters and the round-robin mux arbiter.
// The lock signal exists only when MUX_ARB_LOCK_EN is defined.
interface mux_rr_arbiter_if #(
    parameter int unsigned N     = 32,
    parameter int unsigned SEL_W = 5
);
    logic [N-1:0]     req;
    logic             done;
`ifdef MUX_ARB_LOCK_EN
    logic             lock;
`endif
    logic [SEL_W-1:0] sel;
    logic [N-1:0]     grant;
    logic             gnt_valid;
    logic             timeout;

`ifdef MUX_ARB_LOCK_EN
    modport master (output req, done, lock, input sel, grant, gnt_valid, timeout);
    modport slave  (input req, done, lock, output sel, grant, gnt_valid, timeout);
`else
    modport master (output req, done, input sel, grant, gnt_valid, timeout);
    modport slave  (input req, done, output sel, grant, gnt_valid, timeout);
`endif
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the select of a shared 32:1 word mux, with hold timeout.
// Optional owner lock for atomic multi-beat sequences: define MUX_ARB_LOCK_EN.
module mux_rr_arbiter #(
    parameter int unsigned N        = 32,
    parameter int unsigned SEL_W    = 5,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              rst,
    mux_rr_arbiter_if.slave   bus
);
    localparam int unsigned HOLD_W = 8;
    localparam int unsigned SUM_W  = SEL_W + 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]        state_q, state_nxt;
    logic [SEL_W-1:0]  sel_q, sel_nxt;
    logic [SEL_W-1:0]  last_q, last_nxt;
    logic [N-1:0]      grant_q, grant_nxt;
    logic              gv_q, gv_nxt;
    logic              to_q, to_nxt;
    logic [HOLD_W-1:0] hold_q, hold_nxt;

    logic [N-1:0]      scan_c;
    logic [N-1:0]      rot_c;
    logic [SEL_W-1:0]  start_c;
    logic [SEL_W-1:0]  off_c;
    logic [SEL_W-1:0]  win_c;
    logic [SUM_W-1:0]  sum_c;
    logic              found_c;
    logic              locked_c;
    logic              owner_req_c;
    logic              rel_done_c;
    logic              rel_wd_c;
    logic              rel_to_c;
    logic              release_c;

`ifdef MUX_ARB_LOCK_EN
    assign locked_c = bus.lock;
`else
    assign locked_c = 1'b0;
`endif

    // Current owner is excluded so a releasing owner is never regranted back-to-back.
    assign scan_c  = bus.req & ~grant_q;
    assign start_c = (last_q == SEL_W'(N - 1)) ? '0 : SEL_W'(last_q + 1'b1);
    assign rot_c   = N'({scan_c, scan_c} >> start_c);

    // First set bit of the rotated request vector.
    always_comb begin
        found_c = 1'b0;
        off_c   = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (!found_c && rot_c[i]) begin
                found_c = 1'b1;
                off_c   = SEL_W'(i);
            end
        end
    end

    assign sum_c = SUM_W'(start_c) + SUM_W'(off_c);
    assign win_c = (sum_c >= SUM_W'(N)) ? SEL_W'(sum_c - SUM_W'(N)) : SEL_W'(sum_c);

    assign owner_req_c = |(bus.req & grant_q);
    assign rel_done_c  = (state_q == BUSY) && bus.done && !locked_c;
    assign rel_wd_c    = (state_q == BUSY) && !owner_req_c && !locked_c;
    assign rel_to_c    = (state_q == BUSY) && (hold_q >= HOLD_W'(MAX_HOLD - 1)) && !locked_c;
    assign release_c   = rel_done_c || rel_wd_c || rel_to_c;

    // Next-state and registered-output values.
    always_comb begin
        state_nxt = state_q;
        sel_nxt   = sel_q;
        last_nxt  = last_q;
        grant_nxt = grant_q;
        gv_nxt    = gv_q;
        to_nxt    = 1'b0;
        hold_nxt  = hold_q;

        case (state_q)
            IDLE: begin
                grant_nxt = '0;
                gv_nxt    = 1'b0;
                if (found_c) begin
                    state_nxt = BUSY;
                    sel_nxt   = win_c;
                    last_nxt  = win_c;
                    grant_nxt = N'(1) << win_c;
                    gv_nxt    = 1'b1;
                    hold_nxt  = '0;
                end
            end
            BUSY: begin
                if (!locked_c && (hold_q != HOLD_W'(MAX_HOLD))) begin
                    hold_nxt = HOLD_W'(hold_q + 1'b1);
                end
                if (release_c) begin
                    // Voluntary release (done or withdrawal) suppresses the timeout pulse.
                    to_nxt = !(rel_done_c || rel_wd_c);
                    if (found_c) begin
                        sel_nxt   = win_c;
                        last_nxt  = win_c;
                        grant_nxt = N'(1) << win_c;
                        gv_nxt    = 1'b1;
                        hold_nxt  = '0;
                    end else begin
                        state_nxt = IDLE;
                        grant_nxt = '0;
                        gv_nxt    = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
                gv_nxt    = 1'b0;
            end
        endcase
    end

    // Reset leaves last pointing at N-1 so requester 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            last_q  <= SEL_W'(N - 1);
            grant_q <= '0;
            gv_q    <= 1'b0;
            to_q    <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_nxt;
            sel_q   <= sel_nxt;
            last_q  <= last_nxt;
            grant_q <= grant_nxt;
            gv_q    <= gv_nxt;
            to_q    <= to_nxt;
            hold_q  <= hold_nxt;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.grant     = grant_q;
    assign bus.gnt_valid = gv_q;
    assign bus.timeout   = to_q;

    a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
    a_grant_valid:  assert property (@(posedge clk) disable iff (rst) ((grant_q != '0) == gv_q));
    a_sel_matches:  assert property (@(posedge clk) disable iff (rst) (!gv_q || grant_q[sel_q]));

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: vector table plus multi-cycle sequences.
// Lock sequence is compiled in when MUX_ARB_LOCK_EN is defined.
module tb_mux_rr_arbiter;
    localparam int unsigned N        = 32;
    localparam int unsigned SEL_W    = 5;
    localparam int unsigned MAX_HOLD = 16;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mux_rr_arbiter_if #(.N(N), .SEL_W(SEL_W)) bus ();

    mux_rr_arbiter #(.N(N), .SEL_W(SEL_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [31:0] req;
        logic        done;
        logic [4:0]  sel;
        logic [31:0] grant;
        logic        gv;
        logic        to;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [4:0] esel, input logic [31:0] egnt,
                             input logic egv, input logic eto);
        check({name, ".sel"},       32'(bus.sel),       32'(esel));
        check({name, ".grant"},     bus.grant,          egnt);
        check({name, ".gnt_valid"}, 32'(bus.gnt_valid), 32'(egv));
        check({name, ".timeout"},   32'(bus.timeout),   32'(eto));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.req  = '0;
        bus.done = 1'b0;
`ifdef MUX_ARB_LOCK_EN
        bus.lock = 1'b0;
`endif
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{32'h0000_0001, 1'b0, 5'd0, 32'h0000_0001, 1'b1, 1'b0};
        tbl[1]  = '{32'h0000_0001, 1'b1, 5'd0, 32'h0000_0000, 1'b0, 1'b0};
        tbl[2]  = '{32'h0000_0000, 1'b0, 5'd0, 32'h0000_0000, 1'b0, 1'b0};
        tbl[3]  = '{32'h0000_0008, 1'b0, 5'd3, 32'h0000_0008, 1'b1, 1'b0};
        tbl[4]  = '{32'h0000_0080, 1'b0, 5'd7, 32'h0000_0080, 1'b1, 1'b0};
        tbl[5]  = '{32'h0000_0080, 1'b1, 5'd7, 32'h0000_0000, 1'b0, 1'b0};
        tbl[6]  = '{32'h0000_0080, 1'b0, 5'd7, 32'h0000_0080, 1'b1, 1'b0};
        tbl[7]  = '{32'h0000_0081, 1'b1, 5'd0, 32'h0000_0001, 1'b1, 1'b0};
        tbl[8]  = '{32'h0000_0081, 1'b1, 5'd7, 32'h0000_0080, 1'b1, 1'b0};
        tbl[9]  = '{32'h0000_0000, 1'b1, 5'd7, 32'h0000_0000, 1'b0, 1'b0};
        tbl[10] = '{32'h0000_0000, 1'b1, 5'd7, 32'h0000_0000, 1'b0, 1'b0};
        tbl[11] = '{32'h0000_00A0, 1'b0, 5'd5, 32'h0000_0020, 1'b1, 1'b0};
        tbl[12] = '{32'h0000_00A0, 1'b0, 5'd5, 32'h0000_0020, 1'b1, 1'b0};

        rst      = 1'b1;
        bus.req  = '0;
        bus.done = 1'b0;
`ifdef MUX_ARB_LOCK_EN
        bus.lock = 1'b0;
`endif
        step();
        check_out("reset", 5'd0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            bus.req  = tbl[i].req;
            bus.done = tbl[i].done;
            step();
            check_out($sformatf("vec%0d", i), tbl[i].sel, tbl[i].grant, tbl[i].gv, tbl[i].to);
        end

        // Hold timeout: owner 5 keeps the grant 16 cycles, then 9 takes over.
        do_reset();
        bus.req = 32'h0000_0020;
        step();
        check_out("to_grant5", 5'd5, 32'h0000_0020, 1'b1, 1'b0);
        bus.req = 32'h0000_0220;
        for (int k = 1; k <= 15; k++) begin
            step();
            check_out($sformatf("to_hold%0d", k), 5'd5, 32'h0000_0020, 1'b1, 1'b0);
        end
        step();
        check_out("to_release", 5'd9, 32'h0000_0200, 1'b1, 1'b1);
        step();
        check_out("to_pulse_end", 5'd9, 32'h0000_0200, 1'b1, 1'b0);
        for (int k = 2; k <= 15; k++) begin
            step();
            check($sformatf("hold9_%0d.timeout", k), 32'(bus.timeout), 32'h0);
        end
        // done lands on the same cycle the timeout would fire.
        bus.done = 1'b1;
        step();
        check_out("done_beats_timeout", 5'd5, 32'h0000_0020, 1'b1, 1'b0);
        bus.done = 1'b0;

        // Fairness sweep: every requester served once per 32 grants, no bubbles.
        do_reset();
        bus.req  = '1;
        bus.done = 1'b1;
        for (int i = 0; i <= 32; i++) begin
            step();
            check_out($sformatf("rr%0d", i), 5'(i % 32), 32'(1) << (i % 32), 1'b1, 1'b0);
        end
        bus.done = 1'b0;

        // Asynchronous reset while owner 12 is active.
        do_reset();
        bus.req = 32'h0000_1000;
        step();
        check_out("own12", 5'd12, 32'h0000_1000, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_out("async_rst", 5'd0, 32'h0, 1'b0, 1'b0);
        #2;
        rst     = 1'b0;
        bus.req = 32'h8000_0001;
        step();
        check_out("post_rst0", 5'd0, 32'h0000_0001, 1'b1, 1'b0);
        bus.done = 1'b1;
        step();
        check_out("post_rst31", 5'd31, 32'h8000_0000, 1'b1, 1'b0);
        bus.done = 1'b0;

`ifdef MUX_ARB_LOCK_EN
        // Locked owner ignores done and never times out.
        do_reset();
        bus.req = 32'h0000_0004;
        step();
        check_out("lk_grant2", 5'd2, 32'h0000_0004, 1'b1, 1'b0);
        bus.req  = 32'h0000_0104;
        bus.lock = 1'b1;
        for (int k = 0; k < 40; k++) begin
            bus.done = ((k % 7) == 3);
            step();
            check_out($sformatf("lk%0d", k), 5'd2, 32'h0000_0004, 1'b1, 1'b0);
        end
        bus.lock = 1'b0;
        bus.done = 1'b1;
        step();
        check_out("lk_release", 5'd8, 32'h0000_0100, 1'b1, 1'b0);
        bus.done = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
